// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexers: per-channel buffer state encoding.
package demux_pkg;

  typedef logic [1:0] buf_state_t;

  localparam buf_state_t ST_EMPTY = 2'b00;
  localparam buf_state_t ST_HALF  = 2'b01;
  localparam buf_state_t ST_FULL  = 2'b10;

endpackage

// File: rtl/demux_skid_buf.sv
// Two-entry skid buffer for one demux output channel.
// Handshake: a word moves when valid and ready are both 1 on a rising clk edge; valid/data hold while stalled.
module demux_skid_buf
  import demux_pkg::*;
#(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [n-1:0] push_data,
  output logic         rdy,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  input  logic         out_ready
);

  buf_state_t   state_q, state_d;
  logic [n-1:0] head_q, head_d;
  logic [n-1:0] tail_q, tail_d;
  logic         pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // The top never pushes into a FULL buffer because rdy gates in_ready.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pop     = out_valid & out_ready;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_HALF;
          head_d  = push_data;
        end
      end
      ST_HALF: begin
        if (push && !pop) begin
          state_d = ST_FULL;
          tail_d  = push_data;
        end else if (pop && !push) begin
          state_d = ST_EMPTY;
        end else if (push && pop) begin
          head_d  = push_data;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_HALF;
          head_d  = tail_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    rdy       = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_data  = head_q;
  end

endmodule

// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer; each destination has its own skid buffer.
// Handshake: a word moves when valid and ready are both 1 on a rising clk edge; in_ready only looks at in_sel and buffer state.
module demux_1x2_stream
  import demux_pkg::*;
#(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [n-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready
);

  logic rdy0, rdy1;
  logic in_xfer;
  logic push0, push1;

  assign in_ready = in_sel ? rdy1 : rdy0;
  assign in_xfer  = in_valid & in_ready;
  assign push0    = in_xfer & ~in_sel;
  assign push1    = in_xfer & in_sel;

  demux_skid_buf #(.n(n)) u_buf0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push0),
    .push_data (in_data),
    .rdy       (rdy0),
    .out_valid (out0_valid),
    .out_data  (out0_data),
    .out_ready (out0_ready)
  );

  demux_skid_buf #(.n(n)) u_buf1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push1),
    .push_data (in_data),
    .rdy       (rdy1),
    .out_valid (out1_valid),
    .out_data  (out1_data),
    .out_ready (out1_ready)
  );

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Bench for demux_1x2_stream: per-channel queue model checked every cycle plus directed literal checks.
module tb_demux_1x2_stream;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out0_data;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out1_data;
  logic         out1_valid;
  logic         out1_ready;

  int checks = 0;
  int passes = 0;

  // model: each channel is a queue of at most two words, head is what the consumer sees
  logic [W-1:0] m_q0[$];
  logic [W-1:0] m_q1[$];
  bit           model_live = 1'b0;
  bit           m_acc;

  // words the consumers actually took, compared against literal lists
  logic [W-1:0] seen0[$];
  logic [W-1:0] seen1[$];
  logic [W-1:0] exp_q[$];

  demux_1x2_stream #(.n(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // model update on the active edge
  always @(posedge clk) begin
    if (!reset_n) begin
      m_q0.delete();
      m_q1.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      m_acc = in_valid && (in_sel ? (m_q1.size() < 2) : (m_q0.size() < 2));
      if (m_q0.size() != 0 && out0_ready) void'(m_q0.pop_front());
      if (m_q1.size() != 0 && out1_ready) void'(m_q1.pop_front());
      if (m_acc) begin
        if (in_sel) m_q1.push_back(in_data);
        else        m_q0.push_back(in_data);
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (model_live) begin
      chk("out0_valid", out0_valid, m_q0.size() != 0);
      if (m_q0.size() != 0) chk("out0_data", out0_data, m_q0[0]);
      chk("out1_valid", out1_valid, m_q1.size() != 0);
      if (m_q1.size() != 0) chk("out1_data", out1_data, m_q1[0]);
      chk("in_ready", in_ready, in_sel ? (m_q1.size() < 2) : (m_q0.size() < 2));
      if (reset_n && out0_valid && out0_ready) seen0.push_back(out0_data);
      if (reset_n && out1_valid && out1_ready) seen1.push_back(out1_data);
    end
  end

  // driver tasks
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic [W-1:0] d, output int waited);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_seen(input string name, input bit ch);
    int sz;
    sz = ch ? seen1.size() : seen0.size();
    chk({name, "_count"}, sz, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sz; i++)
      chk(name, ch ? seen1[i] : seen0[i], exp_q[i]);
  endtask

  task automatic clear_seen();
    seen0.delete();
    seen1.delete();
  endtask

  initial begin
    int w;
    reset_n    = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = W'($urandom);
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // reset with in_valid high
    cyc(2);
    @(negedge clk);
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    chk("rst_in_ready_s0", in_ready, 1);
    @(posedge clk); #1;
    in_sel = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_s1", in_ready, 1);
    @(posedge clk); #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    cyc(1);

    // streaming, both consumers ready
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    clear_seen();
    send(1'b0, 8'h11, w); chk("stream_wait", w, 0);
    @(negedge clk);
    chk("stream_lat_valid", out0_valid, 1);
    chk("stream_lat_data", out0_data, 8'h11);
    @(posedge clk); #1;
    send(1'b1, 8'h22, w); chk("stream_wait", w, 0);
    send(1'b0, 8'h33, w); chk("stream_wait", w, 0);
    send(1'b1, 8'h44, w); chk("stream_wait", w, 0);
    cyc(3);
    exp_q = '{8'h11, 8'h33}; check_seen("stream_out0", 1'b0);
    exp_q = '{8'h22, 8'h44}; check_seen("stream_out1", 1'b1);

    // back-pressure on channel 0
    clear_seen();
    out0_ready = 1'b0;
    send(1'b0, 8'hA1, w);
    send(1'b0, 8'hA2, w);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA3;
    cyc(2);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out0_data, 8'hA1);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    send(1'b0, 8'hA3, w);
    cyc(4);
    exp_q = '{8'hA1, 8'hA2, 8'hA3}; check_seen("bp_out0", 1'b0);

    // channel isolation: ch0 full and stalled, ch1 keeps flowing
    clear_seen();
    out0_ready = 1'b0;
    send(1'b0, 8'hC1, w);
    send(1'b0, 8'hC2, w);
    send(1'b1, 8'hB1, w); chk("iso_wait_b1", w, 0);
    send(1'b1, 8'hB2, w); chk("iso_wait_b2", w, 0);
    cyc(3);
    exp_q = '{8'hB1, 8'hB2}; check_seen("iso_out1", 1'b1);
    exp_q = {}; check_seen("iso_out0_stalled", 1'b0);
    out0_ready = 1'b1;
    cyc(3);
    exp_q = '{8'hC1, 8'hC2}; check_seen("iso_out0", 1'b0);

    // simultaneous push and pop in HALF
    clear_seen();
    out0_ready = 1'b0;
    send(1'b0, 8'h05, w);
    out0_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h06;
    @(negedge clk);
    chk("pp_head_before", out0_data, 8'h05);
    chk("pp_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pp_valid_after", out0_valid, 1);
    chk("pp_head_after", out0_data, 8'h06);
    @(posedge clk); #1;
    send(1'b0, 8'hFF, w);
    @(negedge clk);
    chk("pp_all_ones", out0_data, 8'hFF);
    @(posedge clk); #1;
    cyc(2);

    // reset mid-operation with both channels full
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(1'b0, 8'hD1, w);
    send(1'b0, 8'hD2, w);
    send(1'b1, 8'hE1, w);
    send(1'b1, 8'hE2, w);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out0_valid", out0_valid, 0);
    chk("mid_rst_out1_valid", out1_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    clear_seen();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cyc(5);
    exp_q = {};
    check_seen("mid_rst_out0", 1'b0);
    check_seen("mid_rst_out1", 1'b1);

    // randomized traffic, model checked every cycle
    for (int i = 0; i < 800; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_sel     = 1'($urandom_range(0, 1));
      in_data    = W'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    in_valid   = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cyc(4);

    // report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
